// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   OWNER_CPU / OWNER_AUX : encoding of who owns an in-flight read response
//   STARVE_CNT_W          : width of the aux anti-starvation counter
package dmem_arb_pkg;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_AUX = 1'b1;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating anti-starvation counter for the auxiliary requester.
// Ports:
//   clk_i      : clock, rising edge
//   reset_i    : synchronous active-high reset, clears the count
//   inc_i      : count one more CPU win while aux waits
//   clr_i      : clear the count (takes precedence over inc_i)
//   at_limit_o : count has reached STARVE_LIMIT
module arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_reg;
  logic [STARVE_CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr_i) begin
      cnt_next = '0;
    end else if (inc_i && (cnt_reg != LIMIT_C)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign at_limit_o = (cnt_reg == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-ported data memory.
// CPU has fixed priority; the auxiliary master (boot loader / debug DMA) is
// guaranteed a slot after STARVE_LIMIT consecutive CPU wins and may lock
// ownership for bursts. Read data (1-cycle latency) is steered back to the
// requester that issued the read.
// Ports:
//   clk_i, reset_i                       : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/mask_i         : CPU request, held until cpu_gnt_o
//   cpu_gnt_o, cpu_stall_o               : CPU grant, stall when request loses
//   cpu_rvalid_o, cpu_rdata_o            : CPU read response
//   aux_req/we/addr/wdata/mask/lock_i    : auxiliary request plus burst lock
//   aux_gnt_o, aux_rvalid_o, aux_rdata_o : auxiliary grant and response
//   mem_re/we/addr/wdata/mask_o          : memory request (zero when idle)
//   mem_rdata_i                          : memory read data, one cycle after re
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic [3:0]        cpu_mask_i,
  output logic              cpu_gnt_o,
  output logic              cpu_stall_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              aux_req_i,
  input  logic              aux_we_i,
  input  logic [ADDR_W-1:0] aux_addr_i,
  input  logic [DATA_W-1:0] aux_wdata_i,
  input  logic [3:0]        aux_mask_i,
  input  logic              aux_lock_i,
  output logic              aux_gnt_o,
  output logic              aux_rvalid_o,
  output logic [DATA_W-1:0] aux_rdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_mask_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  logic lock_owner_reg;
  logic lock_owner_next;
  logic rsp_pending_reg;
  logic rsp_owner_reg;
  logic starve_hit;
  logic cpu_win;
  logic aux_win;

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .inc_i     (cpu_win & aux_req_i),
    .clr_i     (aux_win | ~aux_req_i),
    .at_limit_o(starve_hit)
  );

  // Priority chain: burst lock, sole requester, starvation relief, CPU.
  // Grants are forced low during reset so nothing reaches the memory.
  always_comb begin
    cpu_win = 1'b0;
    aux_win = 1'b0;
    if (!reset_i) begin
      if (lock_owner_reg && aux_req_i) begin
        aux_win = 1'b1;
      end else if (cpu_req_i && !aux_req_i) begin
        cpu_win = 1'b1;
      end else if (aux_req_i && !cpu_req_i) begin
        aux_win = 1'b1;
      end else if (cpu_req_i && aux_req_i && starve_hit) begin
        aux_win = 1'b1;
      end else if (cpu_req_i) begin
        cpu_win = 1'b1;
      end
    end
  end

  assign cpu_gnt_o   = cpu_win;
  assign aux_gnt_o   = aux_win;
  assign cpu_stall_o = cpu_req_i & ~cpu_win;

  // Memory request mux; idle cycles drive all-zero fields.
  always_comb begin
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_mask_o  = '0;
    if (cpu_win) begin
      mem_re_o    = ~cpu_we_i;
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      mem_mask_o  = cpu_mask_i;
    end else if (aux_win) begin
      mem_re_o    = ~aux_we_i;
      mem_we_o    = aux_we_i;
      mem_addr_o  = aux_addr_i;
      mem_wdata_o = aux_wdata_i;
      mem_mask_o  = aux_mask_i;
    end
  end

  // Lock is taken on a locked aux grant and released as soon as aux either
  // stops asking or stops asserting lock.
  always_comb begin
    lock_owner_next = lock_owner_reg;
    if (aux_win && aux_lock_i) begin
      lock_owner_next = 1'b1;
    end else if (!aux_lock_i || !aux_req_i) begin
      lock_owner_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_owner_reg  <= 1'b0;
      rsp_pending_reg <= 1'b0;
      rsp_owner_reg   <= OWNER_CPU;
    end else begin
      lock_owner_reg  <= lock_owner_next;
      rsp_pending_reg <= mem_re_o;
      rsp_owner_reg   <= aux_win ? OWNER_AUX : OWNER_CPU;
    end
  end

  // Gating with reset_i drops a response whose read was granted just
  // before reset was raised.
  assign cpu_rvalid_o = rsp_pending_reg & (rsp_owner_reg == OWNER_CPU) & ~reset_i;
  assign aux_rvalid_o = rsp_pending_reg & (rsp_owner_reg == OWNER_AUX) & ~reset_i;
  assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
  assign aux_rdata_o  = aux_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, aux_req = 0, aux_we = 0, aux_lock = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, aux_addr = 0, aux_wdata = 0;
  logic [3:0]  cpu_mask = 0, aux_mask = 0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, aux_gnt, aux_rvalid;
  logic [31:0] cpu_rdata, aux_rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t exp_q[$];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .reset_i(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_mask_i(cpu_mask),
    .cpu_gnt_o(cpu_gnt), .cpu_stall_o(cpu_stall),
    .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .aux_req_i(aux_req), .aux_we_i(aux_we), .aux_addr_i(aux_addr),
    .aux_wdata_i(aux_wdata), .aux_mask_i(aux_mask), .aux_lock_i(aux_lock),
    .aux_gnt_o(aux_gnt), .aux_rvalid_o(aux_rvalid), .aux_rdata_o(aux_rdata),
    .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_mask_o(mem_mask), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory environment: a few preloaded words, otherwise an address pattern.
  logic [31:0] mem_arr [bit [31:0]];
  function automatic logic [31:0] mem_value(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= mem_value(mem_addr);
  end

  function automatic void expect_rsp(input logic owner, input logic [31:0] data);
    rsp_t r;
    r.owner = owner;
    r.data  = data;
    r.due   = cyc + 1;
    exp_q.push_back(r);
  endfunction

  // Scoreboard monitor: pops the response due this cycle and compares both ports.
  logic        m_cpu_v, m_aux_v;
  logic [31:0] m_cpu_d, m_aux_d;
  rsp_t        m_r;
  always @(negedge clk) begin
    if (mon_en) begin
      m_cpu_v = 1'b0; m_aux_v = 1'b0; m_cpu_d = '0; m_aux_d = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        m_r = exp_q.pop_front();
        if (m_r.owner == OWNER_CPU) begin m_cpu_v = 1'b1; m_cpu_d = m_r.data; end
        else begin m_aux_v = 1'b1; m_aux_d = m_r.data; end
      end
      checks++;
      if ({cpu_rvalid, aux_rvalid} !== {m_cpu_v, m_aux_v}) begin
        errors++;
        $display("FAIL sb_rvalid cyc=%0d: cpu/aux rvalid got %b%b expected %b%b",
                 cyc, cpu_rvalid, aux_rvalid, m_cpu_v, m_aux_v);
      end
      checks++;
      if ({cpu_rdata, aux_rdata} !== {m_cpu_d, m_aux_d}) begin
        errors++;
        $display("FAIL sb_rdata cyc=%0d: cpu=%h aux=%h expected cpu=%h aux=%h",
                 cyc, cpu_rdata, aux_rdata, m_cpu_d, m_aux_d);
      end
      if (m_cpu_v || m_aux_v)
        $display("rsp cyc=%0d owner=%s data=%h", cyc, m_cpu_v ? "cpu" : "aux",
                 m_cpu_v ? m_cpu_d : m_aux_d);
    end
  end

  task automatic drive_cpu(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_mask = mask;
  endtask

  task automatic drive_aux(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask,
                           input logic lock);
    aux_req = req; aux_we = we; aux_addr = addr; aux_wdata = wdata; aux_mask = mask;
    aux_lock = lock;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_cpu(1, 0, 32'h10, 0, 4'hF);
    drive_aux(1, 0, 32'h20, 0, 4'hF, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_gnt, aux_gnt, mem_re, mem_we} !== 4'b0) begin
      errors++;
      $display("FAIL reset_gnt: gnt/re/we got %b expected 0000",
               {cpu_gnt, aux_gnt, mem_re, mem_we});
    end
    checks++;
    if ({cpu_rvalid, aux_rvalid} !== 2'b0) begin
      errors++;
      $display("FAIL reset_rvalid: got %b expected 00", {cpu_rvalid, aux_rvalid});
    end
    $display("txn reset: gnt=%b%b", cpu_gnt, aux_gnt);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_cpu(0, 0, 0, 0, 0);
    drive_aux(0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_load();
    @(posedge clk); #1;
    drive_cpu(1, 0, 32'h100, 0, 4'hF);
    @(negedge clk);
    checks++;
    if ({cpu_gnt, aux_gnt, mem_re, mem_we, cpu_stall} !== 5'b10100) begin
      errors++;
      $display("FAIL cpu_load_gnt: gnt/agnt/re/we/stall got %b expected 10100",
               {cpu_gnt, aux_gnt, mem_re, mem_we, cpu_stall});
    end
    checks++;
    if (mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL cpu_load_addr: got %h expected 00000100", mem_addr);
    end
    expect_rsp(OWNER_CPU, 32'hDEADBEEF);
    $display("txn cpu_load addr=%h gnt=%b", mem_addr, cpu_gnt);
    @(posedge clk); #1;
    drive_cpu(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, aux_rvalid, cpu_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL cpu_load_rsp: rvalid=%b%b data=%h expected 10 deadbeef",
               cpu_rvalid, aux_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_starve();
    logic exp_aux;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        drive_cpu(1, 0, 32'h10, 0, 4'hF);
        drive_aux(1, 0, 32'h20, 0, 4'hF, 0);
      end
      @(negedge clk);
      exp_aux = ((i % (LIMIT + 1)) == LIMIT);
      checks++;
      if ({cpu_gnt, aux_gnt, cpu_stall} !== {~exp_aux, exp_aux, exp_aux}) begin
        errors++;
        $display("FAIL starve_pattern i=%0d: cgnt/agnt/stall got %b expected %b",
                 i, {cpu_gnt, aux_gnt, cpu_stall}, {~exp_aux, exp_aux, exp_aux});
      end
      if (exp_aux) expect_rsp(OWNER_AUX, mem_value(32'h20));
      else         expect_rsp(OWNER_CPU, mem_value(32'h10));
      $display("txn starve i=%0d winner=%s", i, aux_gnt ? "aux" : "cpu");
    end
    @(posedge clk); #1;
    drive_cpu(0, 0, 0, 0, 0);
    drive_aux(0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_lock_burst();
    int w;
    logic exp_aux;
    w = 0;
    for (int i = 0; i < 20 && w < 3; i++) begin
      @(posedge clk); #1;
      drive_cpu(1, 0, 32'h30, 0, 4'hF);
      drive_aux(1, 0, 32'h40 + 32'(4 * w), 0, 4'hF, w < 2);
      @(negedge clk);
      exp_aux = (w > 0) || (i == LIMIT);
      checks++;
      if ({cpu_gnt, aux_gnt, cpu_stall} !== {~exp_aux, exp_aux, exp_aux}) begin
        errors++;
        $display("FAIL lock_burst i=%0d w=%0d: cgnt/agnt/stall got %b expected %b",
                 i, w, {cpu_gnt, aux_gnt, cpu_stall}, {~exp_aux, exp_aux, exp_aux});
      end
      if (exp_aux) begin
        expect_rsp(OWNER_AUX, mem_value(32'h40 + 32'(4 * w)));
        w++;
      end else begin
        expect_rsp(OWNER_CPU, mem_value(32'h30));
      end
      $display("txn lock_burst i=%0d winner=%s", i, aux_gnt ? "aux" : "cpu");
    end
    @(posedge clk); #1;
    drive_aux(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({cpu_gnt, aux_gnt, cpu_stall} !== 3'b100) begin
      errors++;
      $display("FAIL lock_release: cgnt/agnt/stall got %b expected 100",
               {cpu_gnt, aux_gnt, cpu_stall});
    end
    expect_rsp(OWNER_CPU, mem_value(32'h30));
    $display("txn lock_release winner=%s", cpu_gnt ? "cpu" : "aux");
    @(posedge clk); #1;
    drive_cpu(0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic        own_tbl [7] = '{OWNER_CPU, OWNER_AUX, OWNER_CPU, OWNER_CPU,
                                 OWNER_AUX, OWNER_CPU, OWNER_AUX};
    logic [31:0] addr_tbl [7] = '{32'h10, 32'h20, 32'h14, 32'h10,
                                  32'h20, 32'h10, 32'h24};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (own_tbl[i] == OWNER_CPU) begin
        drive_cpu(1, 0, addr_tbl[i], 0, 4'hF);
        drive_aux(0, 0, 0, 0, 0, 0);
      end else begin
        drive_cpu(0, 0, 0, 0, 0);
        drive_aux(1, 0, addr_tbl[i], 0, 4'hF, 0);
      end
      @(negedge clk);
      checks++;
      if ({cpu_gnt, aux_gnt, mem_addr} !== {~own_tbl[i], own_tbl[i], addr_tbl[i]}) begin
        errors++;
        $display("FAIL b2b_gnt i=%0d: cgnt/agnt=%b%b addr=%h expected %b%b %h",
                 i, cpu_gnt, aux_gnt, mem_addr, ~own_tbl[i], own_tbl[i], addr_tbl[i]);
      end
      expect_rsp(own_tbl[i], mem_value(addr_tbl[i]));
      $display("txn b2b i=%0d owner=%s addr=%h", i, own_tbl[i] ? "aux" : "cpu", addr_tbl[i]);
    end
    @(posedge clk); #1;
    drive_cpu(0, 0, 0, 0, 0);
    drive_aux(0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_aux_store();
    @(posedge clk); #1;
    drive_aux(1, 1, 32'h80, 32'h12345678, 4'b1111, 0);
    @(negedge clk);
    checks++;
    if ({cpu_gnt, aux_gnt, mem_re, mem_we} !== 4'b0101) begin
      errors++;
      $display("FAIL store_strobes: cgnt/agnt/re/we got %b expected 0101",
               {cpu_gnt, aux_gnt, mem_re, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_mask} !== {32'h80, 32'h12345678, 4'b1111}) begin
      errors++;
      $display("FAIL store_fields: addr=%h wdata=%h mask=%b expected 00000080 12345678 1111",
               mem_addr, mem_wdata, mem_mask);
    end
    $display("txn aux_store addr=%h wdata=%h", mem_addr, mem_wdata);
    @(posedge clk); #1;
    drive_aux(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({mem_we, mem_re, mem_addr, mem_wdata, mem_mask} !== 70'b0) begin
      errors++;
      $display("FAIL idle_zero: we=%b re=%b addr=%h wdata=%h mask=%b expected all 0",
               mem_we, mem_re, mem_addr, mem_wdata, mem_mask);
    end
    checks++;
    if ({cpu_rvalid, aux_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL store_no_rvalid: got %b expected 00", {cpu_rvalid, aux_rvalid});
    end
  endtask

  task automatic test_reset_drop();
    // Four contended CPU reads push the starve count to its limit; the last
    // read's response is then killed by reset.
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        drive_cpu(1, 0, 32'h30, 0, 4'hF);
        drive_aux(1, 0, 32'h20, 0, 4'hF, 0);
      end
      @(negedge clk);
      checks++;
      if ({cpu_gnt, aux_gnt} !== 2'b10) begin
        errors++;
        $display("FAIL pre_reset_gnt i=%0d: got %b expected 10", i, {cpu_gnt, aux_gnt});
      end
      if (i < LIMIT - 1) expect_rsp(OWNER_CPU, mem_value(32'h30));
      $display("txn pre_reset i=%0d winner=%s", i, cpu_gnt ? "cpu" : "aux");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_drop: gnt=%b%b rvalid=%b%b expected 0000",
               cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid);
    end
    $display("txn reset_drop rvalid=%b%b", cpu_rvalid, aux_rvalid);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, aux_gnt, cpu_stall} !== 3'b100) begin
      errors++;
      $display("FAIL post_reset_gnt: cgnt/agnt/stall got %b expected 100",
               {cpu_gnt, aux_gnt, cpu_stall});
    end
    expect_rsp(OWNER_CPU, mem_value(32'h30));
    $display("txn post_reset winner=%s", cpu_gnt ? "cpu" : "aux");
    @(posedge clk); #1;
    drive_cpu(0, 0, 0, 0, 0);
    drive_aux(0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    mem_arr[32'h100] = 32'hDEADBEEF;
    mem_arr[32'h10]  = 32'h1010_AAAA;
    mem_arr[32'h20]  = 32'h2020_5555;
    test_reset();
    test_cpu_load();
    test_starve();
    test_lock_burst();
    test_back_to_back();
    test_aux_store();
    test_reset_drop();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
